// File: rtl/alu_seq_mult_if.sv
// Handshake and operand/result bundle for the sequential 4x4 multiplier.
// The master drives start and the operands; the slave (multiplier) returns status and product.
interface alu_seq_mult_if;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/alu_seq_mult.sv
// Sequential 4x4 unsigned shift-add multiplier feeding the ALU multiply mux input.
// Optional ALU_SEQ_MULT_EARLY_EXIT_EN finishes as soon as no multiplier bits remain.
module alu_seq_mult (
  input  logic           clk,
  input  logic           rst,
  alu_seq_mult_if.slave  bus
);
  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]     mplier_q, mplier_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic [PROD_W-1:0]   acc_sum;
  logic                last_step;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath: one multiplier bit consumed per RUN cycle.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    acc_sum   = acc_q;
    last_step = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = PROD_W'(bus.a);
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_sum  = mplier_q[0] ? PROD_W'(acc_q + mcand_q) : acc_q;
        acc_d    = acc_sum;
        mcand_d  = PROD_W'(mcand_q << 1);
        mplier_d = OP_W'(mplier_q >> 1);
        cnt_d    = CNT_W'(cnt_q + 1'b1);
`ifdef ALU_SEQ_MULT_EARLY_EXIT_EN
        last_step = (cnt_q == CNT_W'(3)) || (mplier_d == '0);
`else
        last_step = (cnt_q == CNT_W'(3));
`endif
        if (last_step) begin
          product_d = acc_sum;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule
